tx_engine: RTL and testbench
============================

# tx_engine

UART transmit engine for the TX_Out path. It consumes the single-cycle `load` pulse produced by the upstream rising-edge pulse generator, which is fed by a debounced push-button. It captures an 8-bit byte and serialises it as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, stop bit. Its `tx` output drives the board's UART TX pin directly.

## Interface
- `BAUD_DIV`, 868, clock cycles per serial bit (100 MHz / 115200). Legal range 2..65535; baud counter is 16 bits.
- `clk`  input  1  system clock, rising-edge active
- `reset`  input  1  asynchronous, active-low reset. Low forces reset state immediately, independent of `clk`.
- `load`  input  1  one-clock start pulse from the upstream pulse generator
- `din`  input  8  byte to transmit; sampled only on the accepted `load` edge
- `tx`  output  1  serial line, registered; idles high
- `tx_rdy`  output  1  high when idle and able to accept `load`

## Operation
- Reset values:
  - `tx`=1, `tx_rdy`=1
  - state=IDLE
  - baud counter=0, bit counter=0, shift register=8'h00
- States: IDLE, START, DATA, PARITY (only with `TX_PARITY_EN`), STOP.
- IDLE:
  - `tx`=1, `tx_rdy`=1.
  - `load`=1 at a rising edge → latch `din` into the shift register, clear counters, go to START.
- START:
  - `tx`=0 for `BAUD_DIV` cycles, then go to DATA.
- DATA:
  - `tx` = shift[0]. Each bit is held `BAUD_DIV` cycles, then the shift register shifts right and the bit counter increments.
  - After bit 7 completes: go to PARITY if enabled, else STOP.
- PARITY:
  - `tx` = XOR of the latched byte (even parity), for `BAUD_DIV` cycles, then go to STOP.
- STOP:
  - `tx`=1 for `BAUD_DIV` cycles, then go to IDLE.
- Baud counter:
  - Counts 0..`BAUD_DIV`-1 in every non-IDLE state.
  - Bit advance occurs on the cycle the counter equals `BAUD_DIV`-1; the counter then wraps to 0.
- `load` while not IDLE is ignored entirely: no latch, no queueing, no effect on the frame in progress.
- `din` changes after acceptance do not affect the frame in progress.
- Reset asserted mid-frame:
  - Frame is aborted; `tx` returns high and `tx_rdy` high asynchronously.
  - No partial frame resumes after release.
- `load` held high for multiple cycles (upstream fault):
  - Only the first edge in IDLE is accepted.
  - A new frame starts only if `load` is still high on the first IDLE cycle after STOP.

## Timing
- `load` sampled at rising edge N while IDLE: `tx` falls and `tx_rdy` falls at edge N (visible in cycle N+1).
- Both outputs come straight from flops; no combinational path from `load` or `din` to `tx`.
- Frame length: 10×`BAUD_DIV` cycles, or 11×`BAUD_DIV` with parity.
  - Measured from the `tx` falling edge to the IDLE entry edge.
- `tx_rdy` rises on the same edge that enters IDLE.
- Earliest next `load` is accepted on the following edge, giving at least 1 idle-high clock between the stop bit and the next start bit.
- Data bit k (0..7) occupies cycles [(1+k)×`BAUD_DIV`, (2+k)×`BAUD_DIV`) after the start edge.

## Configuration
- `TX_PARITY_EN` defined:
  - PARITY state is compiled in.
  - Even-parity bit is inserted between data bit 7 and the stop bit.
  - Frame is 11 bits.
- `TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP; frame is 10 bits.

## Test plan
- Reset check, `BAUD_DIV`=4: hold `reset`=0 for 3 clocks, release → `tx`=1, `tx_rdy`=1, no activity for 20 clocks.
- Single frame, `BAUD_DIV`=4, `din`=8'hA5, 1-cycle `load`:
  - `tx` sequence per 4-clock slot: 0,1,0,1,0,0,1,0,1,1.
  - `tx_rdy` low for exactly 40 clocks.
- Busy rejection: during the frame for 8'hA5, pulse `load` with `din`=8'h3C at clocks 10 and 39 → waveform identical to the single-frame case; 8'h3C is never sent.
- Back-to-back: `load` 8'h01 at the first IDLE cycle after a frame, then 8'hFF → second start bit begins exactly 1 clock after the first stop bit ends; both bytes decoded correctly by the bench receiver.
- Mid-frame reset: assert `reset` low at clock 17 of an 8'h55 frame → `tx`=1 and `tx_rdy`=1 before the next clock edge; after release, next `load` 8'h0F sends a clean frame.
- With `TX_PARITY_EN`:
  - `din`=8'h07 → parity slot `tx`=1, frame is 44 clocks at `BAUD_DIV`=4.
  - `din`=8'h03 → parity slot `tx`=0.

Source files
------------

// File: rtl/tx_engine.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Optional parity stage is compiled in with the TX_PARITY_EN macro.
module tx_engine #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_rdy
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef TX_PARITY_EN
    ,PARITY = 3'd4
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        rdy_q, rdy_d;
  logic        baud_end;
`ifdef TX_PARITY_EN
  logic        par_q, par_d;
`endif

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = din;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
`ifdef TX_PARITY_EN
          par_d   = ^din;
`endif
          state_d = START;
        end
      end
      START: if (baud_end) state_d = DATA;
      DATA: begin
        if (baud_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: if (baud_end) state_d = STOP;
`endif
      STOP: if (baud_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so tx/tx_rdy are pure flops.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx     = tx_q;
  assign tx_rdy = rdy_q;

endmodule

// File: tb/tb_tx_engine.sv
// Bench for tx_engine: directed cases plus randomized frames against a frame-level model.
module tb_tx_engine;
  localparam int BD = 4;
`ifdef TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * BD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx, tx_rdy;
  int         n_tests = 0;
  int         n_fail = 0;

  tx_engine #(.BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .load(load), .din(din), .tx(tx), .tx_rdy(tx_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected line level for bit slot s of a frame carrying byte b.
  function automatic logic slot_bit(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
`ifdef TX_PARITY_EN
    if (s == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_rdy", 32'(tx_rdy), 32'd1);
    end
  endtask

  // Caller presents load=1/din=b before the accepting edge. Busy-time load
  // pulses are injected at cycles inj1/inj2 with random din.
  task automatic frame(input logic [7:0] b, input int inj1, input int inj2,
                       input bit chain, input logic [7:0] nb);
    logic       q[$];
    logic [7:0] rx;
    @(posedge clk);
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      check("tx_bit", 32'(tx), 32'(slot_bit(b, k / BD)));
      check("rdy_busy", 32'(tx_rdy), 32'd0);
      q.push_back(tx);
      load = (k == inj1) || (k == inj2);
      din  = 8'($urandom);
    end
    @(negedge clk);
    check("end_tx", 32'(tx), 32'd1);
    check("end_rdy", 32'(tx_rdy), 32'd1);
    check("rx_start", 32'(q[BD/2]), 32'd0);
    for (int i = 0; i < 8; i++) rx[i] = q[(1 + i) * BD + BD / 2];
    check("rx_byte", 32'(rx), 32'(b));
`ifdef TX_PARITY_EN
    check("rx_par", 32'(q[9 * BD + BD / 2]), 32'(^b));
`endif
    check("rx_stop", 32'(q[(NBITS - 1) * BD + BD / 2]), 32'd1);
    load = chain;
    din  = chain ? nb : 8'($urandom);
  endtask

  initial begin
    logic [7:0] b;
    int         gap, i1, i2;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rdy", 32'(tx_rdy), 32'd1);
    reset = 1'b1;
    idle(20);

    // Single frame
    load = 1'b1; din = 8'hA5;
    frame(8'hA5, -1, -1, 1'b0, 8'h00);
    idle(2);

    // Busy rejection
    load = 1'b1; din = 8'hA5;
    frame(8'hA5, 10, 39, 1'b0, 8'h00);
    idle(2);

    // Back-to-back
    load = 1'b1; din = 8'h01;
    frame(8'h01, -1, -1, 1'b1, 8'hFF);
    frame(8'hFF, -1, -1, 1'b0, 8'h00);
    idle(2);

    // Mid-frame reset at clock 17
    load = 1'b1; din = 8'h55;
    @(posedge clk);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      check("pre_rst_tx", 32'(tx), 32'(slot_bit(8'h55, k / BD)));
      load = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_rdy", 32'(tx_rdy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(FL + 4);
    load = 1'b1; din = 8'h0F;
    frame(8'h0F, -1, -1, 1'b0, 8'h00);
    idle(1);

`ifdef TX_PARITY_EN
    load = 1'b1; din = 8'h07;
    frame(8'h07, -1, -1, 1'b0, 8'h00);
    idle(1);
    load = 1'b1; din = 8'h03;
    frame(8'h03, -1, -1, 1'b0, 8'h00);
    idle(1);
`endif

    // Randomized frames, gaps and busy-time load pulses
    for (int n = 0; n < 25; n++) begin
      b   = 8'($urandom);
      gap = int'($urandom_range(0, 4));
      i1  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FL - 1)) : -1;
      i2  = ($urandom_range(0, 3) == 0) ? FL - 1 : int'($urandom_range(0, FL - 1));
      if (gap > 0) idle(gap);
      load = 1'b1; din = b;
      frame(b, i1, i2, 1'b0, 8'h00);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
